oddr_tx_sequencer: RTL

//  Streaming scheduler for one ODDRX1F output lane. Accepts parallel words over a

---
 rtl/oddr_tx_sequencer_if.sv | 31 +++
 rtl/oddr_tx_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/oddr_tx_sequencer_if.sv
// rtl/oddr_tx_sequencer_if.sv - word handshake bundle feeding the ODDR lane sequencer
//
// Purpose: carries one parallel word plus its end-of-frame marker from the
// packet logic (master) to the sequencer (slave).
// Signals:
//   data  WIDTH  word to serialize, held stable while valid & !ready
//   last  1      word closes the frame
//   valid 1      data/last are valid
//   ready 1      slave takes the word on an edge where valid & ready
interface oddr_tx_sequencer_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] data;
  logic             last;
  logic             valid;
  logic             ready;

  modport master (
    output data,
    output last,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  last,
    input  valid,
    output ready
  );
endinterface

// File: rtl/oddr_tx_sequencer.sv
// rtl/oddr_tx_sequencer.sv - gapless two-bit-per-cycle scheduler for one ODDRX1F lane
//
// Purpose: accepts words over the handshake interface and presents two bits
// per SCLK cycle on D0/D1, back-to-back words without a gap. Holds the ODDR
// primitive in reset for RST_HOLD cycles after reset release and pulses
// underrun_o when a frame runs dry before its last word.
// Ports:
//   sclk_i      clock shared with the ODDRX1F
//   rst_i       synchronous reset, active low
//   s_if        slave side of the word handshake (data/last/valid in, ready out)
//   d0_o, d1_o  registered bit pair for ODDRX1F.D0/D1
//   oddr_rst_o  registered, active-high reset for ODDRX1F.RST
//   busy_o      high while d0_o/d1_o carry data beats
//   underrun_o  one-cycle pulse on mid-frame starvation
module oddr_tx_sequencer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter bit IDLE_D0   = 1'b0,
  parameter bit IDLE_D1   = 1'b0,
  parameter int RST_HOLD  = 2
) (
  input  logic                   sclk_i,
  input  logic                   rst_i,
  oddr_tx_sequencer_if.slave     s_if,
  output logic                   d0_o,
  output logic                   d1_o,
  output logic                   oddr_rst_o,
  output logic                   busy_o,
  output logic                   underrun_o
);

  localparam int N  = WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;

  localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(RST_HOLD);

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    beat_q, beat_d;
  logic             last_q, last_d;
  logic             d0_q, d0_d;
  logic             d1_q, d1_d;
  logic             oddr_rst_q, oddr_rst_d;
  logic             underrun_q, underrun_d;
  logic             ready_c;
  logic             load_c;

  always_ff @(posedge sclk_i) begin
    if (!rst_i) begin
      state_q    <= ST_HOLD;
      hold_q     <= HOLD_INIT;
      sh_q       <= '0;
      beat_q     <= '0;
      last_q     <= 1'b0;
      d0_q       <= IDLE_D0;
      d1_q       <= IDLE_D1;
      oddr_rst_q <= 1'b1;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      sh_q       <= sh_d;
      beat_q     <= beat_d;
      last_q     <= last_d;
      d0_q       <= d0_d;
      d1_q       <= d1_d;
      oddr_rst_q <= oddr_rst_d;
      underrun_q <= underrun_d;
    end
  end

  // The beat currently on d0_q/d1_q is beat_q; sh_q holds the bits still to
  // go, pre-aligned so the next pair always sits at the same end.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    sh_d       = sh_q;
    beat_d     = beat_q;
    last_d     = last_q;
    d0_d       = IDLE_D0;
    d1_d       = IDLE_D1;
    oddr_rst_d = 1'b0;
    underrun_d = 1'b0;
    ready_c    = 1'b0;
    load_c     = 1'b0;

    case (state_q)
      ST_HOLD: begin
        // A count of 0 or 1 both leave on this edge, which covers RST_HOLD=0.
        if (hold_q <= HW'(1)) begin
          state_d    = ST_IDLE;
          oddr_rst_d = 1'b0;
        end else begin
          hold_d     = hold_q - HW'(1);
          oddr_rst_d = 1'b1;
        end
      end

      ST_IDLE: begin
        ready_c = 1'b1;
        load_c  = s_if.valid;
      end

      ST_SHIFT: begin
        if (beat_q == LAST_BEAT) begin
          ready_c = 1'b1;
          if (s_if.valid) begin
            load_c = 1'b1;
          end else begin
            state_d    = ST_IDLE;
            underrun_d = ~last_q;
          end
        end else begin
          beat_d = beat_q + CW'(1);
          if (LSB_FIRST) begin
            d0_d = sh_q[0];
            d1_d = sh_q[1];
            sh_d = sh_q >> 2;
          end else begin
            d0_d = sh_q[WIDTH-1];
            d1_d = sh_q[WIDTH-2];
            sh_d = sh_q << 2;
          end
        end
      end

      default: begin
        state_d = ST_HOLD;
      end
    endcase

    // A new word drives beat 0 straight onto the output registers so the
    // first pair appears one edge after the handshake with no bubble.
    if (load_c) begin
      state_d = ST_SHIFT;
      beat_d  = '0;
      last_d  = s_if.last;
      if (LSB_FIRST) begin
        d0_d = s_if.data[0];
        d1_d = s_if.data[1];
        sh_d = s_if.data >> 2;
      end else begin
        d0_d = s_if.data[WIDTH-1];
        d1_d = s_if.data[WIDTH-2];
        sh_d = s_if.data << 2;
      end
    end
  end

  assign s_if.ready = ready_c;
  assign d0_o       = d0_q;
  assign d1_o       = d1_q;
  assign oddr_rst_o = oddr_rst_q;
  assign busy_o     = (state_q == ST_SHIFT);
  assign underrun_o = underrun_q;

endmodule
